// File: rtl/ravenoc_wh_arbiter.sv
// ----------------------------------------------------------------------------
// ravenoc_wh_arbiter
// Wormhole output-port arbiter for one RaveNoC router output link.
// Shares the link among NUM_REQ input ports with round-robin fairness. A head
// flit locks the output to its requester until that packet's tail flit has
// been transferred. No flit storage: the grant is combinational from the
// request inputs and the registered arbitration state.
//
// Ports
//   clk          router clock
//   arst         asynchronous reset, active-low
//   req_valid_i  flit valid per input port
//   req_ftype_i  flit type per port (2 bits each): 00 HEAD, 01 BODY,
//                10 TAIL, 11 HEAD_TAIL
//   req_ready_o  flit accepted from port i this cycle
//   out_valid_o  flit presented on the output link
//   out_ready_i  downstream accepts the flit
//   grant_o      one-hot mux select (all-zero when nothing is granted)
//   grant_idx_o  binary index of grant_o (0 when nothing is granted)
//   locked_o     registered: output owned by an in-flight packet
//   err_o        registered one-cycle pulse on a HEAD seen inside a packet
// ----------------------------------------------------------------------------
module ravenoc_wh_arbiter #(
    parameter  int NUM_REQ = 5,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [2*NUM_REQ-1:0]   req_ftype_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   locked_o,
    output logic                   err_o
);

    localparam logic [1:0] FT_HEAD      = 2'b00;
    localparam logic [1:0] FT_BODY      = 2'b01;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] eligible_s;
    logic               win_found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               grant_vld_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [1:0]         sel_ftype_s;
    logic               out_valid_s;
    logic               xfer_s;

    // Index of the port after idx, wrapping the last port back to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX) begin
            return '0;
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    // Only HEAD or HEAD_TAIL flits may open a new packet.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = req_valid_i[i] &&
                            ((req_ftype_i[2*i +: 2] == FT_HEAD) ||
                             (req_ftype_i[2*i +: 2] == FT_HEAD_TAIL));
        end
    end

    // Round-robin search starting at ptr_q; first eligible port wins.
    always_comb begin
        logic [IDX_W:0] cand;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end else begin
                cand = cand;
            end
            if (!win_found_s && eligible_s[cand[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // While locked the owner keeps the grant even through bubbles.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        if (state_q == ST_LOCKED) begin
            grant_vld_s = 1'b1;
            grant_idx_s = owner_q;
        end else begin
            grant_vld_s = win_found_s;
            grant_idx_s = win_idx_s;
        end
    end

    // One-hot grant, granted flit type and handshake.
    always_comb begin
        grant_s = '0;
        if (grant_vld_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        sel_ftype_s = req_ftype_i[2*int'(grant_idx_s) +: 2];
        out_valid_s = |(grant_s & req_valid_i);
        xfer_s      = out_valid_s & out_ready_i;
    end

    // Packet lock, pointer advance on completion, protocol-error detection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s && (sel_ftype_s == FT_HEAD)) begin
                    state_d = ST_LOCKED;
                    owner_d = grant_idx_s;
                end else if (xfer_s && (sel_ftype_s == FT_HEAD_TAIL)) begin
                    ptr_d = next_idx(grant_idx_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (!xfer_s) begin
                    state_d = ST_LOCKED;
                end else begin
                    case (sel_ftype_s)
                        FT_TAIL, FT_HEAD_TAIL: begin
                            state_d = ST_IDLE;
                            ptr_d   = next_idx(owner_q);
                        end
                        // Stray head inside a packet is forwarded as a body flit.
                        FT_HEAD: begin
                            err_d = 1'b1;
                        end
                        FT_BODY: begin
                            state_d = ST_LOCKED;
                        end
                        default: begin
                            state_d = ST_LOCKED;
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                owner_d = '0;
            end
        endcase
    end

    // Arbitration state registers; reset abandons any in-flight packet.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign grant_o     = grant_s;
    assign grant_idx_o = grant_idx_s;
    assign out_valid_o = out_valid_s;
    assign req_ready_o = grant_s & {NUM_REQ{out_ready_i}};
    assign locked_o    = (state_q == ST_LOCKED);
    assign err_o       = err_q;

endmodule

// File: tb/tb_ravenoc_wh_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ravenoc_wh_arbiter
// Directed bench for the wormhole arbiter (NUM_REQ = 5). Inputs change #1
// after a rising edge; combinational outputs are checked #1 after that and
// registered outputs #1 after the following rising edge.
// ----------------------------------------------------------------------------
module tb_ravenoc_wh_arbiter;

    localparam int N = 5;
    localparam logic [1:0] HD = 2'b00;
    localparam logic [1:0] BD = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] HT = 2'b11;

    logic           clk;
    logic           arst;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_ftype;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic [2:0]     grant_idx;
    logic           locked;
    logic           err;

    int n_cmp;
    int n_bad;

    ravenoc_wh_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .arst        (arst),
        .req_valid_i (req_valid),
        .req_ftype_i (req_ftype),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .locked_o    (locked),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [1:0] t);
        req_valid[p]        = v;
        req_ftype[2*p +: 2] = t;
    endtask

    task automatic clear_ports();
        req_valid = '0;
        req_ftype = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_ports();
        out_ready = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        tick();
    endtask

    initial begin
        logic [N-1:0] t2_exp [5];
        n_cmp     = 0;
        n_bad     = 0;
        arst      = 1'b1;
        out_ready = 1'b0;
        clear_ports();

        // T1: reset with every port holding a HEAD
        for (int i = 0; i < N; i++) set_port(i, 1'b1, HD);
        @(negedge clk);
        arst = 1'b0;
        tick();
        tick();
        chk("t1_locked_in_reset", 32'(locked), 32'd0);
        chk("t1_err_in_reset", 32'(err), 32'd0);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("t1_grant_after_rel", 32'(grant), 32'h01);
        chk("t1_idx_after_rel", 32'(grant_idx), 32'd0);

        // T2: ports 0,2,4 HEAD_TAIL -> grants 0,2,4,0,2
        do_reset();
        set_port(0, 1'b1, HT);
        set_port(2, 1'b1, HT);
        set_port(4, 1'b1, HT);
        out_ready = 1'b1;
        t2_exp = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t2_grant_%0d", k), 32'(grant), 32'(t2_exp[k]));
            tick();
            chk($sformatf("t2_locked_%0d", k), 32'(locked), 32'd0);
        end

        // T3: port1 HEAD,BODY,BODY,TAIL while port3 holds HEAD
        do_reset();
        set_port(3, 1'b1, HD);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_port(1, 1'b1, (k == 0) ? HD : ((k == 3) ? TL : BD));
            #1;
            chk($sformatf("t3_grant_%0d", k), 32'(grant), 32'h02);
            chk($sformatf("t3_ready3_%0d", k), 32'(req_ready[3]), 32'd0);
            chk($sformatf("t3_locked_%0d", k), 32'(locked), (k == 0) ? 32'd0 : 32'd1);
            tick();
        end
        set_port(1, 1'b0, HD);
        out_ready = 1'b0;
        #1;
        chk("t3_port3_grant", 32'(grant), 32'h08);
        chk("t3_port3_idx", 32'(grant_idx), 32'd3);
        chk("t3_unlocked", 32'(locked), 32'd0);

        // T4: locked on port2, backpressure then bubbles
        do_reset();
        set_port(2, 1'b1, HD);
        out_ready = 1'b1;
        tick();
        chk("t4_locked", 32'(locked), 32'd1);
        set_port(2, 1'b1, BD);
        set_port(0, 1'b1, HD);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_bp_grant_%0d", k), 32'(grant), 32'h04);
            chk($sformatf("t4_bp_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t4_bp_ready_%0d", k), 32'(req_ready), 32'h00);
            tick();
        end
        set_port(2, 1'b0, BD);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t4_bub_grant_%0d", k), 32'(grant), 32'h04);
            chk($sformatf("t4_bub_valid_%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("t4_bub_ready_%0d", k), 32'(req_ready), 32'h04);
            tick();
            chk($sformatf("t4_bub_locked_%0d", k), 32'(locked), 32'd1);
        end

        // T5: HEAD inside a packet on port0; stray BODY on port4 in IDLE
        do_reset();
        set_port(0, 1'b1, HD);
        out_ready = 1'b1;
        tick();
        chk("t5_locked", 32'(locked), 32'd1);
        chk("t5_err_before", 32'(err), 32'd0);
        tick();
        chk("t5_err_pulse", 32'(err), 32'd1);
        chk("t5_locked_on_err", 32'(locked), 32'd1);
        set_port(0, 1'b1, BD);
        tick();
        chk("t5_err_cleared", 32'(err), 32'd0);
        set_port(0, 1'b1, TL);
        tick();
        chk("t5_unlocked", 32'(locked), 32'd0);
        clear_ports();
        set_port(4, 1'b1, BD);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t5_stray_grant_%0d", k), 32'(grant), 32'h00);
            chk($sformatf("t5_stray_valid_%0d", k), 32'(out_valid), 32'd0);
            tick();
        end

        // T6: wrap after port4 packet, then async reset mid-packet
        do_reset();
        out_ready = 1'b1;
        set_port(3, 1'b1, HT);
        #1;
        chk("t6_port3_grant", 32'(grant), 32'h08);
        tick();
        clear_ports();
        set_port(4, 1'b1, HD);
        tick();
        chk("t6_port4_locked", 32'(locked), 32'd1);
        set_port(4, 1'b1, TL);
        tick();
        chk("t6_port4_done", 32'(locked), 32'd0);
        set_port(0, 1'b1, HT);
        set_port(4, 1'b1, HT);
        out_ready = 1'b0;
        #1;
        chk("t6_wrap_grant", 32'(grant), 32'h01);
        chk("t6_wrap_idx", 32'(grant_idx), 32'd0);
        // move ptr to 3, then lock on port3
        clear_ports();
        set_port(2, 1'b1, HT);
        out_ready = 1'b1;
        tick();
        clear_ports();
        set_port(3, 1'b1, HD);
        tick();
        chk("t6_mid_locked", 32'(locked), 32'd1);
        set_port(3, 1'b1, BD);
        #2;
        arst = 1'b0;
        #1;
        chk("t6_async_unlock", 32'(locked), 32'd0);
        @(negedge clk);
        arst = 1'b1;
        clear_ports();
        set_port(0, 1'b1, HD);
        set_port(3, 1'b1, HD);
        out_ready = 1'b0;
        #1;
        chk("t6_ptr_reset_grant", 32'(grant), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
